vga_fb_arbiter: RTL
===================

# vga_fb_arbiter

Shares one single-port framebuffer RAM between the VGA pixel fetch and two write requesters: requester 0 is the CPU bus bridge and requester 1 is the sprite/animation engine. It sits between the 800x600 timing generator and the RAM. During active video the read fetch owns the port and drives `o_rgb`. Writes are scheduled round-robin only while the timing generator reports no active pixel. A frame counter and a one-cycle frame interrupt are derived from `i_screenend`.

## Interface
- `FB_W`, 200: framebuffer width in stored pixels.
- `FB_H`, 150: framebuffer height in stored pixels.
- `SHIFT`, 2: screen-to-framebuffer downscale; 800x600 maps to 200x150.
- `AW`, 15: RAM address width. `FB_W*FB_H` must be ≤ 2^AW.
- `DW`, 9: pixel width (RGB 3:3:3).
- `i_clk` in 1: pixel clock, same clock as the timing generator.
- `i_rst_n` in 1: reset, asynchronous assert, active-low.
- `i_active` in 1: high while a visible pixel is being drawn.
- `i_screenend` in 1: high one pixel before the end of the frame.
- `i_x` in 11, `i_y` in 10: current pixel position, 0..799 and 0..599.
- `i_req0`/`i_req1` in 1: write request. Held with its address/data until the matching ack.
- `i_addr0`/`i_addr1` in AW: write address.
- `i_data0`/`i_data1` in DW: write data.
- `o_ack0`/`o_ack1` out 1: one-cycle write-accepted pulse.
- `o_mem_addr` out AW, `o_mem_wdata` out DW, `o_mem_we` out 1: RAM port.
- `i_mem_rdata` in DW: RAM read data, valid one cycle after the address is presented.
- `o_rgb` out DW: pixel to DAC. 0 outside active video.
- `o_frame` out 16: frame counter.
- `o_frame_irq` out 1: one-cycle pulse per frame.
- `o_err` out 1: sticky out-of-range write flag.

## Operation
- Reset values: all outputs 0. FSM is in IDLE. Round-robin pointer `last` = 1, so requester 0 wins the first tie.
- **Fetch address:** `((i_y>>SHIFT)*FB_W) + (i_x>>SHIFT)`. Compute it at full AW width; the maximum is 29999.
  - While `i_active`=1: `o_mem_addr` = fetch address and `o_mem_we` = 0. This overrides all writer state.
- **IDLE**
  - If `i_active`=0 and either request is high, select a winner.
    - Both requesting: the one not equal to `last` wins.
    - Latch the winner's address, data and id, then go to WRITE.
  - If `i_active`=1, requests are not sampled.
- **WRITE**
  - If `i_active`=0 this cycle:
    - `o_mem_addr`/`o_mem_wdata` = latched values.
    - `o_mem_we` = 1 if the latched address < `FB_W*FB_H`, else 0 and `o_err` is set.
    - `o_ack[id]` = 1, `last` = id, next state is IDLE.
  - If `i_active`=1: the write is stalled. Stay in WRITE with no ack and `we`=0. Retry each cycle until `i_active`=0.
- **Write rate:** at most one write per 2 cycles, because WRITE always returns to IDLE. A requester that holds its request through the ack cycle cannot be double-written.
- **Out-of-range writes** are still acknowledged, so requesters never hang. `o_err` clears only on reset.
- **Frame counter:** `o_frame` increments by 1 and `o_frame_irq` pulses in the cycle after `i_screenend`=1. Wraps 0xFFFF→0.
- **Reset mid-operation:** the FSM returns to IDLE immediately. The latched write is discarded with no ack and no `we`. `o_rgb` and the pipeline clear.

## Timing
- **Pixel path:** `i_x`/`i_y`/`i_active` in cycle N → address N → `i_mem_rdata` N+1 → `o_rgb` registered at the edge ending N+1.
  - `o_rgb` is valid at N+2 and is gated by `i_active` delayed 2 cycles.
  - Total latency is 2 cycles. The timing generator's sync outputs must be delayed 2 cycles externally.
- **Write latency:** a request sampled in IDLE at cycle N gets `o_ack`/`o_mem_we` at cycle N+1 if `i_active`=0 at N+1. Otherwise the ack comes at the first later cycle with `i_active`=0.
- `o_ack*` and `o_mem_we` are combinational from state and `i_active`. Downstream must sample them on the clock edge.
- **Simultaneous events:** a request arriving in the same cycle `i_active` rises is not sampled. `i_screenend` does not interact with the write FSM.

## Test plan
- **Fetch path:** preload the RAM with addr→addr[8:0]. Sweep active video at `i_y`=5, `i_x`=0..15.
  - Required: `o_rgb` at N+2 = (1*200 + x>>2)[8:0], i.e. 200 for x=0..3 and 201 for x=4..7.
  - Required: `o_mem_we`=0 throughout.
- **Single writer in blanking:** `i_active`=0, `i_req0` with addr 100, data 0x1AB.
  - Required: the next cycle has `o_mem_we`=1, addr 100, `o_ack0`=1.
  - Required: with `i_req0` held high, the second ack comes only after IDLE resamples, 2 cycles apart.
- **Contention:** both requesters high continuously in blanking.
  - Required: acks alternate 0,1,0,1, one ack every 2 cycles.
- **Stall:** grant in IDLE, then `i_active` rises for 10 cycles.
  - Required: no `we`/ack for 10 cycles and fetch addresses are driven.
  - Required: the ack comes in the first cycle after `i_active` falls.
- **Out of range:** write to addr 30000.
  - Required: `o_ack`=1, `o_mem_we`=0, `o_err`=1 and it stays set until `i_rst_n`=0.
- **Frame/reset:** pulse `i_screenend` 3 times.
  - Required: `o_frame`=3 with 3 single-cycle irq pulses.
  - Assert `i_rst_n`=0 during WRITE. Required: `o_frame`=0, no ack, FSM in IDLE.

Source files
------------

// File: rtl/vga_fb_arbiter_if.sv
// Bundle between the VGA timing generator, the two write requesters, the framebuffer RAM and the arbiter.
// master: the surrounding system (drives i_*); slave: the arbiter (drives o_*).
interface vga_fb_arbiter_if #(
    parameter int AW = 15,
    parameter int DW = 9
);
    logic          i_active;
    logic          i_screenend;
    logic [10:0]   i_x;
    logic [9:0]    i_y;
    logic          i_req0;
    logic          i_req1;
    logic [AW-1:0] i_addr0;
    logic [AW-1:0] i_addr1;
    logic [DW-1:0] i_data0;
    logic [DW-1:0] i_data1;
    logic          o_ack0;
    logic          o_ack1;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wdata;
    logic          o_mem_we;
    logic [DW-1:0] i_mem_rdata;
    logic [DW-1:0] o_rgb;
    logic [15:0]   o_frame;
    logic          o_frame_irq;
    logic          o_err;

    modport master (
        output i_active, i_screenend, i_x, i_y,
        output i_req0, i_req1, i_addr0, i_addr1, i_data0, i_data1,
        output i_mem_rdata,
        input  o_ack0, o_ack1, o_mem_addr, o_mem_wdata, o_mem_we,
        input  o_rgb, o_frame, o_frame_irq, o_err
    );

    modport slave (
        input  i_active, i_screenend, i_x, i_y,
        input  i_req0, i_req1, i_addr0, i_addr1, i_data0, i_data1,
        input  i_mem_rdata,
        output o_ack0, o_ack1, o_mem_addr, o_mem_wdata, o_mem_we,
        output o_rgb, o_frame, o_frame_irq, o_err
    );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Shares one single-port framebuffer RAM between VGA pixel fetch and two round-robin blanking-time writers.
// Latency: pixel 2 cycles (x/y to o_rgb); write ack 1 cycle after IDLE sample, later if active video intervenes.
// Backpressure: active video stalls a granted write (held in WRITE, no ack); requesters hold until ack.
module vga_fb_arbiter #(
    parameter int FB_W  = 200,
    parameter int FB_H  = 150,
    parameter int SHIFT = 2,
    parameter int AW    = 15,
    parameter int DW    = 9
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    vga_fb_arbiter_if.slave bus
);
    localparam int FB_SIZE = FB_W * FB_H;

    typedef enum logic {
        S_IDLE,
        S_WRITE
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    logic          r_id;
    logic          r_last;
    logic          r_err;
    logic          r_act_d1;
    logic [DW-1:0] r_rgb;
    logic [15:0]   r_frame;
    logic          r_irq;

    logic [AW-1:0] w_x_fb;
    logic [AW-1:0] w_y_fb;
    logic [AW-1:0] w_fetch_addr;
    logic          w_req_any;
    logic          w_grant;
    logic          w_write_go;
    logic          w_in_range;

    assign w_x_fb       = AW'(bus.i_x >> SHIFT);
    assign w_y_fb       = AW'(bus.i_y >> SHIFT);
    assign w_fetch_addr = (w_y_fb * AW'(FB_W)) + w_x_fb;

    // On a tie the requester that did not write last wins.
    assign w_req_any  = bus.i_req0 | bus.i_req1;
    assign w_grant    = (bus.i_req0 & bus.i_req1) ? ~r_last : bus.i_req1;
    assign w_write_go = (r_state == S_WRITE) && !bus.i_active;
    assign w_in_range = (int'(r_addr) < FB_SIZE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_data  <= '0;
            r_id    <= 1'b0;
            r_last  <= 1'b1;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!bus.i_active && w_req_any) begin
                        r_addr  <= w_grant ? bus.i_addr1 : bus.i_addr0;
                        r_data  <= w_grant ? bus.i_data1 : bus.i_data0;
                        r_id    <= w_grant;
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    // Out-of-range writes still complete so the requester is released.
                    if (!bus.i_active) begin
                        r_last  <= r_id;
                        r_state <= S_IDLE;
                        if (!w_in_range) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_act_d1 <= 1'b0;
            r_rgb    <= '0;
            r_frame  <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_act_d1 <= bus.i_active;
            r_rgb    <= r_act_d1 ? bus.i_mem_rdata : '0;
            r_irq    <= bus.i_screenend;
            if (bus.i_screenend) begin
                r_frame <= r_frame + 16'd1;
            end
        end
    end

    // Active video owns the RAM port regardless of writer state.
    assign bus.o_mem_addr  = bus.i_active ? w_fetch_addr : r_addr;
    assign bus.o_mem_wdata = r_data;
    assign bus.o_mem_we    = w_write_go && w_in_range;
    assign bus.o_ack0      = w_write_go && !r_id;
    assign bus.o_ack1      = w_write_go && r_id;
    assign bus.o_rgb       = r_rgb;
    assign bus.o_frame     = r_frame;
    assign bus.o_frame_irq = r_irq;
    assign bus.o_err       = r_err;
endmodule
